mdio_arbiter_ctrl: RTL and testbench

MDIO_ARBITER_CTRL -- requirements
Module: mdio_arbiter_ctrl

---
 rtl/mdio_pkg.sv | 51 +++++
 rtl/mdio_rr_arb.sv | 28 ++
 rtl/mdio_arbiter_ctrl.sv | 148 ++++++++++++++
 tb/tb_mdio_arbiter_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdio_pkg.sv
// rtl/mdio_pkg.sv - shared MDIO frame constants, field positions and FSM encoding
package mdio_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEND    = 3'd1,
        ST_TA      = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4,
        ST_GAP     = 3'd5
    } mdio_state_t;

    localparam logic [1:0] FRAME_START = 2'b01;
    localparam logic [1:0] FRAME_TA    = 2'b10;
    localparam logic [1:0] OPCODE_WR   = 2'b01;
    localparam logic [1:0] OPCODE_RD   = 2'b10;

    localparam int START_MSB = 31;
    localparam int START_LSB = 30;
    localparam int OP_MSB    = 29;
    localparam int OP_LSB    = 28;
    localparam int PHY_MSB   = 27;
    localparam int PHY_LSB   = 23;
    localparam int REG_MSB   = 22;
    localparam int REG_LSB   = 18;
    localparam int TA_MSB    = 17;
    localparam int TA_LSB    = 16;
    localparam int DATA_MSB  = 15;
    localparam int DATA_LSB  = 0;

    // Terminal values of the 5-bit bit counter in each serial phase.
    localparam logic [4:0] LAST_WR_BIT  = 5'd31;
    localparam logic [4:0] LAST_HDR_BIT = 5'd13;
    localparam logic [4:0] LAST_TA_BIT  = 5'd1;
    localparam logic [4:0] LAST_CAP_BIT = 5'd15;

    function automatic logic [31:0] build_frame(input logic        rd,
                                                input logic [9:0]  addr,
                                                input logic [15:0] data);
        logic [31:0] f;
        f                        = '0;
        f[START_MSB:START_LSB]   = FRAME_START;
        f[OP_MSB:OP_LSB]         = rd ? OPCODE_RD : OPCODE_WR;
        f[PHY_MSB:PHY_LSB]       = addr[9:5];
        f[REG_MSB:REG_LSB]       = addr[4:0];
        f[TA_MSB:TA_LSB]         = FRAME_TA;
        f[DATA_MSB:DATA_LSB]     = rd ? 16'h0000 : data;
        return f;
    endfunction

endpackage

// File: rtl/mdio_rr_arb.sv
// rtl/mdio_rr_arb.sv - two-way round-robin arbiter with registered last-grant
module mdio_rr_arb (
    input  logic clk,
    input  logic reset,
    input  logic req_a,
    input  logic req_b,
    input  logic advance,
    output logic grant_a,
    output logic grant_b
);

    // last_b = 1 means B won the previous grant, so A wins the next tie.
    logic last_b;

    always_comb begin
        grant_a = req_a & (~req_b | last_b);
        grant_b = req_b & (~req_a | ~last_b);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_b <= 1'b1;
        end else if (advance && (grant_a || grant_b)) begin
            last_b <= grant_b;
        end
    end

endmodule

// File: rtl/mdio_arbiter_ctrl.sv
// rtl/mdio_arbiter_ctrl.sv - two-requester MDIO management frame controller
module mdio_arbiter_ctrl
    import mdio_pkg::*;
#(
    parameter int IDLE_GAP = 2
) (
    input  logic        MDC,
    input  logic        reset,
    input  logic        REQ_A,
    input  logic        REQ_B,
    input  logic        OP_A,
    input  logic        OP_B,
    input  logic [9:0]  ADDR_A,
    input  logic [9:0]  ADDR_B,
    input  logic [15:0] DATA_A,
    input  logic [15:0] DATA_B,
    output logic        ACK_A,
    output logic        ACK_B,
    output logic [15:0] RD_DATA_A,
    output logic [15:0] RD_DATA_B,
    output logic        MDIO_OUT,
    output logic        MDIO_OE,
    input  logic        MDIO_IN,
    output logic        BUSY
);

    localparam logic [3:0] GAP_LAST = 4'(IDLE_GAP - 1);

    mdio_state_t state, state_nxt;
    logic [4:0]  bit_cnt;
    logic [3:0]  gap_cnt;
    logic [30:0] frame_sr;
    logic [14:0] rd_sr;
    logic        op_rd;
    logic        sel_b;

    logic        grant_a, grant_b;
    logic [31:0] new_frame;
    logic        oe_nxt, out_nxt, ack_a_nxt, ack_b_nxt, busy_nxt;

    mdio_rr_arb u_arb (
        .clk     (MDC),
        .reset   (reset),
        .req_a   (REQ_A),
        .req_b   (REQ_B),
        .advance (state == ST_IDLE),
        .grant_a (grant_a),
        .grant_b (grant_b)
    );

    assign new_frame = grant_b ? build_frame(OP_B, ADDR_B, DATA_B)
                               : build_frame(OP_A, ADDR_A, DATA_A);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (grant_a || grant_b) state_nxt = ST_SEND;
            end
            ST_SEND: begin
                if (op_rd && bit_cnt == LAST_HDR_BIT)      state_nxt = ST_TA;
                else if (!op_rd && bit_cnt == LAST_WR_BIT) state_nxt = ST_DONE;
            end
            ST_TA: begin
                if (bit_cnt == LAST_TA_BIT) state_nxt = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (bit_cnt == LAST_CAP_BIT) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                state_nxt = ST_GAP;
            end
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Output values for the next cycle, registered below.
        oe_nxt    = (state_nxt == ST_SEND);
        out_nxt   = 1'b0;
        if (state_nxt == ST_SEND) begin
            out_nxt = (state == ST_IDLE) ? new_frame[31] : frame_sr[30];
        end
        ack_a_nxt = (state != ST_DONE) && (state_nxt == ST_DONE) && !sel_b;
        ack_b_nxt = (state != ST_DONE) && (state_nxt == ST_DONE) && sel_b;
        busy_nxt  = (state_nxt != ST_IDLE);
    end

    always_ff @(posedge MDC) begin
        if (reset) begin
            state     <= ST_IDLE;
            bit_cnt   <= 5'd0;
            gap_cnt   <= 4'd0;
            frame_sr  <= '0;
            rd_sr     <= '0;
            op_rd     <= 1'b0;
            sel_b     <= 1'b0;
            MDIO_OE   <= 1'b0;
            MDIO_OUT  <= 1'b0;
            ACK_A     <= 1'b0;
            ACK_B     <= 1'b0;
            RD_DATA_A <= 16'h0000;
            RD_DATA_B <= 16'h0000;
            BUSY      <= 1'b0;
        end else begin
            state    <= state_nxt;
            MDIO_OE  <= oe_nxt;
            MDIO_OUT <= out_nxt;
            ACK_A    <= ack_a_nxt;
            ACK_B    <= ack_b_nxt;
            BUSY     <= busy_nxt;

            if (state_nxt == state &&
                (state == ST_SEND || state == ST_TA || state == ST_CAPTURE)) begin
                bit_cnt <= bit_cnt + 5'd1;
            end else begin
                bit_cnt <= 5'd0;
            end

            if (state == ST_GAP && state_nxt == ST_GAP) begin
                gap_cnt <= gap_cnt + 4'd1;
            end else begin
                gap_cnt <= 4'd0;
            end

            // Bit 31 leaves straight from new_frame; the rest shift out of frame_sr.
            if (state == ST_IDLE && state_nxt == ST_SEND) begin
                sel_b    <= grant_b;
                op_rd    <= grant_b ? OP_B : OP_A;
                frame_sr <= new_frame[30:0];
            end else if (state == ST_SEND) begin
                frame_sr <= {frame_sr[29:0], 1'b0};
            end

            if (state == ST_CAPTURE) begin
                rd_sr <= {rd_sr[13:0], MDIO_IN};
                if (state_nxt == ST_DONE) begin
                    if (sel_b) RD_DATA_B <= {rd_sr, MDIO_IN};
                    else       RD_DATA_A <= {rd_sr, MDIO_IN};
                end
            end
        end
    end

endmodule

// File: tb/tb_mdio_arbiter_ctrl.sv
// tb/tb_mdio_arbiter_ctrl.sv - self-checking bench for mdio_arbiter_ctrl
module tb_mdio_arbiter_ctrl;

    localparam int GAP = 3;

    logic        MDC = 1'b0;
    logic        reset;
    logic        REQ_A, REQ_B, OP_A, OP_B;
    logic [9:0]  ADDR_A, ADDR_B;
    logic [15:0] DATA_A, DATA_B;
    logic        ACK_A, ACK_B;
    logic [15:0] RD_DATA_A, RD_DATA_B;
    logic        MDIO_OUT, MDIO_OE, MDIO_IN, BUSY;

    int checks = 0;
    int failures = 0;
    logic [15:0] exp_rd [2];

    mdio_arbiter_ctrl #(.IDLE_GAP(GAP)) dut (
        .MDC(MDC), .reset(reset),
        .REQ_A(REQ_A), .REQ_B(REQ_B), .OP_A(OP_A), .OP_B(OP_B),
        .ADDR_A(ADDR_A), .ADDR_B(ADDR_B), .DATA_A(DATA_A), .DATA_B(DATA_B),
        .ACK_A(ACK_A), .ACK_B(ACK_B), .RD_DATA_A(RD_DATA_A), .RD_DATA_B(RD_DATA_B),
        .MDIO_OUT(MDIO_OUT), .MDIO_OE(MDIO_OE), .MDIO_IN(MDIO_IN), .BUSY(BUSY)
    );

    always #5 MDC = ~MDC;

    function automatic logic [31:0] model_frame(input bit op, input logic [9:0] addr,
                                                input logic [15:0] data);
        return (32'd1 << 30) + ((op ? 32'd2 : 32'd1) << 28) + (32'(addr) << 18)
             + (32'd2 << 16) + (op ? 32'd0 : 32'(data));
    endfunction

    task automatic step;
        @(posedge MDC); #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        REQ_A = 0; REQ_B = 0; OP_A = 0; OP_B = 0;
        ADDR_A = '0; ADDR_B = '0; DATA_A = '0; DATA_B = '0; MDIO_IN = 0;
        step; step;
        @(negedge MDC);
        checks++;
        if ({MDIO_OE, MDIO_OUT, ACK_A, ACK_B, BUSY} !== 5'b0 ||
            RD_DATA_A !== 16'h0 || RD_DATA_B !== 16'h0) begin
            failures++;
            $display("FAIL reset_state got oe=%b out=%b acka=%b ackb=%b busy=%b rda=%h rdb=%h exp all 0",
                     MDIO_OE, MDIO_OUT, ACK_A, ACK_B, BUSY, RD_DATA_A, RD_DATA_B);
        end
        exp_rd[0] = 16'h0; exp_rd[1] = 16'h0;
        step;
        reset = 1'b0;
    endtask

    task automatic test_idle;
        int act;
        act = 0;
        for (int i = 0; i < 20; i++) begin
            step;
            @(negedge MDC);
            if (MDIO_OE || ACK_A || ACK_B || BUSY || MDIO_OUT) act++;
        end
        checks++;
        if (act !== 0) begin
            failures++;
            $display("FAIL idle_quiet got active_cycles=%0d exp 0", act);
        end
        step;
    endtask

    // One frame from one requester; call at posedge+1.
    task automatic do_frame(input bit who_b, input bit op, input logic [9:0] addr,
                            input logic [15:0] data, input logic [15:0] rdat,
                            input bit drop_mid, input string tag);
        logic [31:0] exp_f, exp_oe, got_out, got_oe;
        int waited, ack_bad;
        exp_f = model_frame(op, addr, data);
        exp_oe = op ? ~((32'd1 << 18) - 32'd1) : 32'hFFFF_FFFF;
        if (who_b) begin OP_B = op; ADDR_B = addr; DATA_B = data; REQ_B = 1; end
        else       begin OP_A = op; ADDR_A = addr; DATA_A = data; REQ_A = 1; end
        waited = 0;
        @(negedge MDC);
        while (MDIO_OE !== 1'b1 && waited < 40) begin
            step; @(negedge MDC); waited++;
        end
        checks++;
        if (waited >= 40) begin
            failures++;
            $display("FAIL %s grant_timeout got no MDIO_OE exp frame start", tag);
            REQ_A = 0; REQ_B = 0;
            step;
            return;
        end
        got_out = '0; got_oe = '0; ack_bad = 0;
        for (int k = 1; k <= 32; k++) begin
            if (k > 1) begin
                step;
                MDIO_IN = (k >= 17) ? rdat[32-k] : 1'($urandom);
                if (k == 5) begin
                    if (who_b) begin OP_B = 1'($urandom); ADDR_B = 10'($urandom); DATA_B = 16'($urandom); end
                    else       begin OP_A = 1'($urandom); ADDR_A = 10'($urandom); DATA_A = 16'($urandom); end
                end
                if (k == 10 && drop_mid) begin
                    if (who_b) begin REQ_B = 0; DATA_B = ~data; end
                    else       begin REQ_A = 0; DATA_A = ~data; end
                end
                @(negedge MDC);
            end
            got_oe[32-k] = MDIO_OE;
            got_out[32-k] = MDIO_OUT;
            if (ACK_A || ACK_B) ack_bad++;
        end
        checks++;
        if (got_oe !== exp_oe) begin
            failures++;
            $display("FAIL %s oe_pattern got=%h exp=%h", tag, got_oe, exp_oe);
        end
        checks++;
        if (got_out !== (exp_f & exp_oe)) begin
            failures++;
            $display("FAIL %s frame_bits got=%h exp=%h", tag, got_out, exp_f & exp_oe);
        end
        checks++;
        if (ack_bad !== 0) begin
            failures++;
            $display("FAIL %s early_ack got=%0d exp 0", tag, ack_bad);
        end
        step;
        MDIO_IN = 0;
        @(negedge MDC);
        if (op) exp_rd[who_b] = rdat;
        checks++;
        if (ACK_A !== !who_b || ACK_B !== who_b || MDIO_OE !== 1'b0 || MDIO_OUT !== 1'b0) begin
            failures++;
            $display("FAIL %s ack_cycle got acka=%b ackb=%b oe=%b out=%b exp acka=%b ackb=%b oe=0 out=0",
                     tag, ACK_A, ACK_B, MDIO_OE, MDIO_OUT, !who_b, who_b);
        end
        checks++;
        if ((who_b ? RD_DATA_B : RD_DATA_A) !== exp_rd[who_b]) begin
            failures++;
            $display("FAIL %s rd_data got=%h exp=%h", tag,
                     who_b ? RD_DATA_B : RD_DATA_A, exp_rd[who_b]);
        end
        if (who_b) REQ_B = 0; else REQ_A = 0;
        step;
        @(negedge MDC);
        checks++;
        if (ACK_A !== 1'b0 || ACK_B !== 1'b0) begin
            failures++;
            $display("FAIL %s ack_single_pulse got acka=%b ackb=%b exp 0 0", tag, ACK_A, ACK_B);
        end
        step;
    endtask

    task automatic test_directed;
        do_frame(0, 0, 10'h0A3, 16'hBEEF, 16'h0000, 0, "write_a");
        do_frame(1, 1, 10'h021, 16'h0000, 16'h1234, 0, "read_b");
    endtask

    task automatic test_random;
        for (int i = 0; i < 10; i++) begin
            do_frame(1'($urandom), 1'($urandom), 10'($urandom), 16'($urandom),
                     16'($urandom), 0, "random");
        end
    endtask

    task automatic test_back_to_back;
        int order[$];
        int gaps[$];
        int busy_lows[$];
        int low_run, busy_low, both_hi;
        bit in_gap;
        reset = 1'b1;
        OP_A = 0; OP_B = 0; ADDR_A = 10'($urandom); ADDR_B = 10'($urandom);
        DATA_A = 16'($urandom); DATA_B = 16'($urandom);
        REQ_A = 1; REQ_B = 1;
        step; step;
        reset = 1'b0;
        exp_rd[0] = 16'h0; exp_rd[1] = 16'h0;
        in_gap = 0; low_run = 0; busy_low = 0; both_hi = 0;
        for (int c = 0; c < 400 && order.size() < 4; c++) begin
            @(negedge MDC);
            if (ACK_A && ACK_B) both_hi++;
            if (in_gap) begin
                if (MDIO_OE) begin
                    gaps.push_back(low_run);
                    busy_lows.push_back(busy_low);
                    in_gap = 0;
                end else begin
                    low_run++;
                    if (!BUSY) busy_low++;
                end
            end
            if (ACK_A || ACK_B) begin
                order.push_back(ACK_B ? 1 : 0);
                in_gap = 1; low_run = 1; busy_low = 0;
            end
            step;
        end
        REQ_A = 0; REQ_B = 0;
        checks++;
        if (order.size() !== 4) begin
            failures++;
            $display("FAIL alternate_count got=%0d exp 4", order.size());
        end
        for (int i = 0; i < order.size(); i++) begin
            checks++;
            if (order[i] !== (i % 2)) begin
                failures++;
                $display("FAIL alternate_order idx=%0d got=%0d exp=%0d", i, order[i], i % 2);
            end
        end
        // Bus idle run: DONE cycle, IDLE_GAP cycles of GAP, one IDLE arbitration cycle.
        for (int i = 0; i < gaps.size(); i++) begin
            checks++;
            if (gaps[i] !== GAP + 2 || busy_lows[i] !== 1) begin
                failures++;
                $display("FAIL idle_gap idx=%0d got low=%0d busy_low=%0d exp low=%0d busy_low=1",
                         i, gaps[i], busy_lows[i], GAP + 2);
            end
        end
        checks++;
        if (both_hi !== 0) begin
            failures++;
            $display("FAIL both_ack got=%0d exp 0", both_hi);
        end
        repeat (45) step;
    endtask

    task automatic test_reset_mid_frame;
        int waited, acks;
        do_frame(1, 1, 10'h155, 16'h0, 16'hA5C3, 0, "pre_reset_read");
        OP_A = 0; ADDR_A = 10'h2F1; DATA_A = 16'h5A5A; REQ_A = 1;
        waited = 0;
        @(negedge MDC);
        while (MDIO_OE !== 1'b1 && waited < 40) begin
            step; @(negedge MDC); waited++;
        end
        checks++;
        if (waited >= 40) begin
            failures++;
            $display("FAIL reset_mid grant_timeout got no MDIO_OE exp frame start");
        end
        for (int k = 2; k <= 10; k++) begin
            step; @(negedge MDC);
        end
        reset = 1'b1;
        step;
        reset = 1'b0;
        REQ_A = 0;
        exp_rd[0] = 16'h0; exp_rd[1] = 16'h0;
        @(negedge MDC);
        checks++;
        if ({MDIO_OE, MDIO_OUT, BUSY, ACK_A, ACK_B} !== 5'b0 || RD_DATA_B !== 16'h0) begin
            failures++;
            $display("FAIL reset_mid_state got oe=%b out=%b busy=%b acka=%b ackb=%b rdb=%h exp all 0",
                     MDIO_OE, MDIO_OUT, BUSY, ACK_A, ACK_B, RD_DATA_B);
        end
        acks = 0;
        for (int i = 0; i < 40; i++) begin
            step; @(negedge MDC);
            if (ACK_A || ACK_B || MDIO_OE) acks++;
        end
        checks++;
        if (acks !== 0) begin
            failures++;
            $display("FAIL reset_mid_abort got active=%0d exp 0", acks);
        end
        step;
        do_frame(0, 0, 10'h3C7, 16'h1357, 16'h0, 0, "post_reset_write");
    endtask

    task automatic test_drop_mid_frame;
        int starts;
        do_frame(0, 0, 10'h0C4, 16'hCAFE, 16'h0, 1, "drop_a");
        starts = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge MDC);
            if (MDIO_OE || ACK_A) starts++;
            step;
        end
        checks++;
        if (starts !== 0) begin
            failures++;
            $display("FAIL drop_no_restart got active=%0d exp 0", starts);
        end
    endtask

    initial begin
        test_reset;
        test_idle;
        test_directed;
        test_random;
        test_back_to_back;
        test_reset_mid_frame;
        test_drop_mid_frame;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
